// File: rtl/serial_tx_pkg.sv
// Shared types and helpers for the parametrised serial transmitter.
package serial_tx_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam logic BIT_ORDER_MSB = 1'b1;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/serial_tx_param_word_change_det.sv
// Remembers the last launched word and raises a load trigger on start or on a new word.
module word_change_det #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_in,
  input  logic             i_start,
  output logic             o_trigger
);

  logic [WIDTH-1:0] r_in_q;

  assign o_trigger = i_start | (i_in != r_in_q);

  // Latch the word being launched so an unchanged input does not retrigger.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_in_q <= '0;
    end else if (o_trigger) begin
      r_in_q <= i_in;
    end else begin
      r_in_q <= r_in_q;
    end
  end

endmodule

// File: rtl/serial_tx_param.sv
// Parallel-in/serial-out transmitter with configurable width and bit order.
module serial_tx_param
  import serial_tx_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter logic MSB_FIRST = BIT_ORDER_MSB,
  parameter logic IDLE_BIT  = 1'b0,
  localparam int  CNT_W     = clog2_min1(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_in,
  input  logic             i_start,
  output logic             o_bit,
  output logic             o_stop,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_bit_idx
);

  localparam int   LAST_M1 = (WIDTH > 1) ? (WIDTH - 2) : 0;
  localparam logic SINGLE  = (WIDTH == 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [WIDTH-1:0] w_shifted;
  logic             r_bit;
  logic             w_bit_nxt;
  logic [CNT_W-1:0] r_idx;
  logic [CNT_W-1:0] w_idx_nxt;
  logic             r_stop;
  logic             w_stop_nxt;
  logic             r_busy;
  logic             w_trigger;

  word_change_det #(.WIDTH(WIDTH)) u_det (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_in      (i_in),
    .i_start   (i_start),
    .o_trigger (w_trigger)
  );

  assign w_shifted = MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);

  // Next-state logic: a trigger reloads from any state, otherwise shift until the last bit.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_bit_nxt   = r_bit;
    w_idx_nxt   = r_idx;
    w_stop_nxt  = r_stop;
    if (w_trigger) begin
      w_shift_nxt = i_in;
      w_bit_nxt   = MSB_FIRST ? i_in[WIDTH-1] : i_in[0];
      w_idx_nxt   = '0;
      w_stop_nxt  = SINGLE;
      w_state_nxt = SINGLE ? ST_IDLE : ST_SHIFT;
    end else begin
      case (r_state)
        ST_SHIFT: begin
          w_shift_nxt = w_shifted;
          w_bit_nxt   = MSB_FIRST ? w_shifted[WIDTH-1] : w_shifted[0];
          w_idx_nxt   = r_idx + CNT_W'(1);
          if (r_idx == CNT_W'(LAST_M1)) begin
            w_stop_nxt  = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_stop_nxt  = 1'b0;
            w_state_nxt = ST_SHIFT;
          end
        end
        ST_IDLE: begin
          w_stop_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
        default: begin
          w_stop_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_bit   <= IDLE_BIT;
      r_idx   <= '0;
      r_stop  <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_bit   <= w_bit_nxt;
      r_idx   <= w_idx_nxt;
      r_stop  <= w_stop_nxt;
      r_busy  <= ~w_stop_nxt;
    end
  end

  assign o_bit     = r_bit;
  assign o_stop    = r_stop;
  assign o_busy    = r_busy;
  assign o_bit_idx = r_idx;

endmodule

// File: tb/tb_serial_tx_param.sv
// Bench for serial_tx_param: three configurations checked against a word/position model.
module tb_serial_tx_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // A: WIDTH=8 MSB first, idle 0
  logic       a_rst_n = 1'b1, a_start = 1'b0;
  logic [7:0] a_in = 8'd0;
  logic       a_bit, a_stop, a_busy;
  logic [2:0] a_idx;
  serial_tx_param #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_a (
    .i_clk(clk), .i_rst_n(a_rst_n), .i_in(a_in), .i_start(a_start),
    .o_bit(a_bit), .o_stop(a_stop), .o_busy(a_busy), .o_bit_idx(a_idx));

  // B: WIDTH=12 LSB first, idle 1
  logic        b_rst_n = 1'b1, b_start = 1'b0;
  logic [11:0] b_in = 12'd0;
  logic        b_bit, b_stop, b_busy;
  logic [3:0]  b_idx;
  serial_tx_param #(.WIDTH(12), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_b (
    .i_clk(clk), .i_rst_n(b_rst_n), .i_in(b_in), .i_start(b_start),
    .o_bit(b_bit), .o_stop(b_stop), .o_busy(b_busy), .o_bit_idx(b_idx));

  // C: WIDTH=1, idle 0
  logic       c_rst_n = 1'b1, c_start = 1'b0;
  logic [0:0] c_in = 1'b0;
  logic       c_bit, c_stop, c_busy;
  logic [0:0] c_idx;
  serial_tx_param #(.WIDTH(1), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_c (
    .i_clk(clk), .i_rst_n(c_rst_n), .i_in(c_in), .i_start(c_start),
    .o_bit(c_bit), .o_stop(c_stop), .o_busy(c_busy), .o_bit_idx(c_idx));

  // Model: the word on the line and the position k within it; bit k leaves in the configured order.
  logic [7:0]  ma_q = 8'd0, ma_word = 8'd0;
  int          ma_k = 0;
  logic        ma_act = 1'b0, ma_bit = 1'b0;
  logic [11:0] mb_q = 12'd0, mb_word = 12'd0;
  int          mb_k = 0;
  logic        mb_act = 1'b0, mb_bit = 1'b1;
  logic        mc_q = 1'b0, mc_bit = 1'b0;

  always @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      ma_q = 8'd0; ma_word = 8'd0; ma_k = 0; ma_act = 1'b0; ma_bit = 1'b0;
    end else if (a_start || a_in != ma_q) begin
      ma_q = a_in; ma_word = a_in; ma_k = 0; ma_act = 1'b1; ma_bit = ma_word[7];
    end else if (ma_act) begin
      ma_k++;
      ma_bit = ma_word[7 - ma_k];
      if (ma_k == 7) ma_act = 1'b0;
    end
  end

  always @(posedge clk or negedge b_rst_n) begin
    if (!b_rst_n) begin
      mb_q = 12'd0; mb_word = 12'd0; mb_k = 0; mb_act = 1'b0; mb_bit = 1'b1;
    end else if (b_start || b_in != mb_q) begin
      mb_q = b_in; mb_word = b_in; mb_k = 0; mb_act = 1'b1; mb_bit = mb_word[0];
    end else if (mb_act) begin
      mb_k++;
      mb_bit = mb_word[mb_k];
      if (mb_k == 11) mb_act = 1'b0;
    end
  end

  always @(posedge clk or negedge c_rst_n) begin
    if (!c_rst_n) begin
      mc_q = 1'b0; mc_bit = 1'b0;
    end else if (c_start || c_in[0] != mc_q) begin
      mc_q = c_in[0]; mc_bit = c_in[0];
    end
  end

  // Compare every DUT output with the model on each falling edge.
  always @(negedge clk) begin
    chk("A_bit", a_bit, ma_bit);   chk("A_stop", a_stop, !ma_act);
    chk("A_busy", a_busy, ma_act); chk("A_idx", a_idx, ma_k);
    chk("B_bit", b_bit, mb_bit);   chk("B_stop", b_stop, !mb_act);
    chk("B_busy", b_busy, mb_act); chk("B_idx", b_idx, mb_k);
    chk("C_bit", c_bit, mc_bit);   chk("C_stop", c_stop, 1'b1);
    chk("C_busy", c_busy, 1'b0);   chk("C_idx", c_idx, 0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0]  seq1 = 8'b00110101;
  logic [7:0]  seq2 = 8'b00101001;
  logic [7:0]  seq5 = 8'b11001100;
  logic [11:0] seqb = 12'hA5C;

  initial begin
    #1;
    a_rst_n = 1'b0; b_rst_n = 1'b0; c_rst_n = 1'b0;
    step();
    chk("rst_A_bit", a_bit, 1'b0); chk("rst_A_stop", a_stop, 1'b1);
    chk("rst_A_busy", a_busy, 1'b0); chk("rst_A_idx", a_idx, 0);
    chk("rst_B_bit", b_bit, 1'b1); chk("rst_B_stop", b_stop, 1'b1);
    a_rst_n = 1'b1; b_rst_n = 1'b1; c_rst_n = 1'b1;

    // Plan 1: plain MSB-first word, then idle hold
    a_in = seq1;
    for (int e = 0; e < 8; e++) begin
      step();
      chk("t1_bit", a_bit, seq1[7-e]);
      chk("t1_stop", a_stop, (e == 7));
      chk("t1_idx", a_idx, e);
    end
    for (int e = 0; e < 3; e++) begin
      step();
      chk("t1_idle_bit", a_bit, 1'b1);
      chk("t1_idle_stop", a_stop, 1'b1);
    end

    // Plan 2: restart mid-word via input change
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    chk("t2_b0", a_bit, 1'b0); chk("t2_s0", a_stop, 1'b0);
    step(); chk("t2_b1", a_bit, 1'b0); chk("t2_s1", a_stop, 1'b0);
    step(); chk("t2_b2", a_bit, 1'b1); chk("t2_s2", a_stop, 1'b0);
    a_in = seq2;
    for (int e = 0; e < 8; e++) begin
      step();
      chk("t2_bit", a_bit, seq2[7-e]);
      chk("t2_stop", a_stop, (e == 7));
    end

    // Plan 3: 12-bit LSB-first word via start
    b_in = seqb; b_start = 1'b1;
    for (int e = 0; e < 12; e++) begin
      step();
      b_start = 1'b0;
      chk("t3_bit", b_bit, seqb[e]);
      chk("t3_idx", b_idx, e);
      chk("t3_stop", b_stop, (e == 11));
    end

    // Plan 4: all-zero word needs start; second start resends
    a_rst_n = 1'b0; a_in = 8'd0;
    step();
    a_rst_n = 1'b1;
    for (int e = 0; e < 3; e++) begin
      step();
      chk("t4_nostart_stop", a_stop, 1'b1);
      chk("t4_nostart_bit", a_bit, 1'b0);
    end
    for (int r = 0; r < 2; r++) begin
      a_start = 1'b1;
      for (int e = 0; e < 8; e++) begin
        step();
        a_start = 1'b0;
        chk("t4_bit", a_bit, 1'b0);
        chk("t4_stop", a_stop, (e == 7));
      end
      step();
    end

    // Plan 5: asynchronous reset mid-word, then resend from scratch
    a_in = seq5;
    for (int e = 0; e < 4; e++) begin
      step();
      chk("t5_pre_bit", a_bit, seq5[7-e]);
    end
    #1 a_rst_n = 1'b0;
    #1;
    chk("t5_rst_stop", a_stop, 1'b1); chk("t5_rst_bit", a_bit, 1'b0);
    chk("t5_rst_idx", a_idx, 0);      chk("t5_rst_busy", a_busy, 1'b0);
    #4 a_rst_n = 1'b1;
    for (int e = 0; e < 4; e++) begin
      step();
      chk("t5_post_bit", a_bit, seq5[7-e]);
      chk("t5_post_stop", a_stop, 1'b0);
    end

    // Plan 6: single-bit width
    c_in = 1'b1;
    step();
    chk("t6_bit1", c_bit, 1'b1); chk("t6_stop1", c_stop, 1'b1); chk("t6_busy1", c_busy, 1'b0);
    c_in = 1'b0;
    step();
    chk("t6_bit0", c_bit, 1'b0); chk("t6_stop0", c_stop, 1'b1);

    // Random traffic: occasional start pulses, word changes and resets
    for (int cyc = 0; cyc < 600; cyc++) begin
      step();
      a_start = ($urandom_range(0, 9) == 0);
      b_start = ($urandom_range(0, 9) == 0);
      c_start = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 11) == 0) a_in = 8'($urandom);
      if ($urandom_range(0, 17) == 0) b_in = 12'($urandom);
      if ($urandom_range(0, 3) == 0)  c_in = 1'($urandom);
      a_rst_n = ($urandom_range(0, 59) != 0);
      b_rst_n = ($urandom_range(0, 79) != 0);
    end
    a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
